rom_streamer: RTL
=================

// Module: rom_streamer
// PURPOSE
//   Read-side sequencer for the 16x8 asynchronous ROM.
//   - On a start pulse, walks an inclusive address range first..last and
//     drives each address onto the ROM address bus.
//   - Registers each returned byte and offers it on a valid/ready byte stream,
//     typically to the UART transmitter.
//   - Sits between the ROM and the serial TX path; the ROM is its only data source.
// PARAMETERS
//   ADDR_W  4  ROM address width; the walk wraps modulo 2**ADDR_W
//   DATA_W  8  ROM data width and stream byte width
// PORTS
//   clk_i       in   1       system clock, single clock domain
//   rst_i       in   1       synchronous, active-high reset
//   start_i     in   1       one-cycle request; sampled only in IDLE
//   first_i     in   ADDR_W  first address of range; captured with start_i
//   last_i      in   ADDR_W  last address of range (inclusive); captured with start_i
//   addr_o      out  ADDR_W  address to ROM addr_i
//   data_i      in   DATA_W  byte from ROM data_o (combinational return)
//   tx_data_o   out  DATA_W  stream byte
//   tx_valid_o  out  1       stream byte valid
//   tx_ready_i  in   1       sink accepts byte
//   busy_o      out  1       high whenever state != IDLE
//   done_o      out  1       one-cycle pulse after the final byte is accepted
// BEHAVIOUR
//   Clocking and reset
//   - One clock; reset is synchronous and active-high.
//   - Reset: state=IDLE; addr_o, tx_data_o, tx_valid_o, busy_o and done_o all 0.
//   - Reset wins over every other event, including mid-transfer: the next
//     state is IDLE, no done_o pulse is produced, and the pending byte is dropped.
//   States
//   - IDLE: if start_i=1, capture last_q<=last_i, set addr_o<=first_i, go to LOAD.
//     Otherwise addr_o holds its value.
//   - LOAD: tx_data_o<=data_i, tx_valid_o<=1, go to SEND. This cycle lets the
//     async ROM output settle on the stable addr_o.
//   - SEND: addr_o and tx_data_o are held constant while tx_valid_o=1.
//     Handshake = tx_valid_o & tx_ready_i, evaluated at the clock edge.
//     On handshake, tx_valid_o<=0, then:
//       - if addr_o==last_q, go to DONE;
//       - else addr_o<=addr_o+1 (mod 2**ADDR_W) and go to LOAD.
//     Without a handshake, remain in SEND indefinitely.
//   - DONE: done_o=1 for exactly this one cycle; go to IDLE.
//   Timing
//   - start_i sampled at edge k -> tx_valid_o high after edge k+1.
//   - With tx_ready_i held at 1: one byte every 2 cycles; done_o is high in the
//     cycle after the last handshake.
//   Boundary conditions
//   - first_i==last_i: exactly one byte is sent.
//   - first_i>last_i: the walk wraps through 2**ADDR_W-1 to 0 and ends at last_q.
//   - start_i in LOAD, SEND or DONE: ignored, not queued. first_i/last_i
//     changes after capture have no effect.
//   - start_i in the cycle after DONE (IDLE again): accepted normally.
//   - tx_valid_o never drops without a handshake. Bytes are never skipped or
//     duplicated.
// TESTING
//   Bench pairs the block with the 16-entry ROM holding 0x41..0x49, 0x50..0x56.
//   1. Reset held 3 cycles -> all outputs 0, busy_o=0; start_i during reset is ignored.
//   2. first=0, last=15, ready=1 -> 16 bytes 41..49,50..56 in order, valid
//      every 2nd cycle, one done_o pulse, busy_o low afterwards.
//   3. first=2, last=4, ready low 5 cycles on byte 0x44 -> tx_data_o=0x44 and
//      addr_o=3 stable throughout; then 0x45 is sent and done_o pulses.
//   4. first=14, last=1 -> bytes 0x55, 0x56, 0x41, 0x42 (address wrap), then done_o.
//   5. first=last=3 -> single byte 0x44; start_i pulsed while busy produces no
//      extra bytes and no second done_o.
//   6. rst_i asserted in SEND (first=0, last=15, after byte 5) -> next cycle
//      IDLE with all outputs 0, no done_o; a fresh start replays from 0x41.

Source files
------------

// File: rtl/rom_streamer.sv
// Read-side sequencer for the 16x8 asynchronous ROM: walks an inclusive,
// wrapping address range and offers each returned byte on a valid/ready stream.
module rom_streamer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_i,
    input  logic [ADDR_W-1:0] last_i,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [ADDR_W-1:0] last_q, last_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic              valid_q, valid_next;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            last_q  <= last_next;
            data_q  <= data_next;
            valid_q <= valid_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        last_next  = last_q;
        data_next  = data_q;
        valid_next = valid_q;
        case (state)
            IDLE: begin
                if (start_i) begin
                    last_next  = last_i;
                    addr_next  = first_i;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // addr_q has been stable for a full cycle, so the ROM output is settled.
                data_next  = data_i;
                valid_next = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (valid_q && tx_ready_i) begin
                    valid_next = 1'b0;
                    if (addr_q == last_q) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr_q + 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign addr_o     = addr_q;
    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

endmodule
